// File: rtl/sha256_msg_pad_pkg.sv
// Shared definitions for the SHA-256 message padder: FSM states and block geometry.
// Optional idle-timeout message termination is enabled by defining SHA_PAD_TIMEOUT_EN.
package sha256_msg_pad_pkg;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_PAD,
    ST_LEN,
    ST_EMIT
  } pad_state_t;

  localparam int unsigned BLK_W     = 512;
  localparam int unsigned BLK_BYTES = BLK_W / 8;
  localparam logic [7:0]  PAD_BYTE  = 8'h80;
  localparam int unsigned LEN_POS   = 56;

endpackage

// File: rtl/sha256_pad_buf.sv
// 64-byte block buffer: single-byte write at index, 8-byte big-endian length write at
// LEN_POS, synchronous clear. Byte 0 is presented on flat[511:504].
import sha256_msg_pad_pkg::*;

module sha256_pad_buf (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [5:0]       wr_idx,
  input  logic [7:0]       wr_byte,
  input  logic             len_en,
  input  logic [63:0]      len_val,
  output logic [BLK_W-1:0] flat
);

  logic [7:0] mem [BLK_BYTES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BLK_BYTES; i++) mem[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < BLK_BYTES; i++) mem[i] <= '0;
    end else begin
      if (wr_en) mem[wr_idx] <= wr_byte;
      if (len_en) begin
        for (int unsigned k = 0; k < 8; k++) mem[LEN_POS + k] <= len_val[63 - 8*k -: 8];
      end
    end
  end

  for (genvar g = 0; g < BLK_BYTES; g++) begin : g_flat
    assign flat[BLK_W - 1 - 8*g -: 8] = mem[g];
  end

endmodule

// File: rtl/sha256_msg_pad.sv
// Packs a byte stream into 512-bit SHA-256 blocks with 0x80 / zero / 64-bit length padding.
// Define SHA_PAD_TIMEOUT_EN to end a message implicitly after TIMEOUT_CYC idle cycles.
import sha256_msg_pad_pkg::*;

module sha256_msg_pad #(
  parameter int unsigned LEN_W       = 32,
  parameter int unsigned TIMEOUT_CYC = 80000
) (
  input  logic             CLK,
  input  logic             KEY,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_end,
  output logic             in_ready,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             blk_first,
  output logic             blk_last,
  output logic             ovf
);

  pad_state_t       state, state_n;
  logic [6:0]       ptr, ptr_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic             first_pend, first_n;
  logic             last_q, last_n;
  logic             end_pend, endp_n;
  logic             pad_done, padd_n;
  logic             ovf_q;

  logic             buf_clr, buf_wr, buf_len;
  logic [7:0]       buf_byte;
  logic [63:0]      len_val;
  logic             timeout_hit;
  logic             end_evt;

`ifdef SHA_PAD_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt;

  always_ff @(posedge CLK or negedge KEY) begin
    if (!KEY) begin
      idle_cnt <= '0;
    end else if (state != ST_FILL || cnt == '0 || in_valid || timeout_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ST_FILL) && (cnt != '0) && (idle_cnt == TO_W'(TIMEOUT_CYC));
`else
  // Timeout logic absent; the parameter stays so overrides remain legal in this build.
  assign timeout_hit = (TIMEOUT_CYC == 0) && 1'b0;
`endif

  assign end_evt = in_end | timeout_hit;

  always_comb begin
    len_val = '0;
    len_val[LEN_W+2:0] = {cnt, 3'b000};
  end

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    cnt_n    = cnt;
    first_n  = first_pend;
    last_n   = last_q;
    endp_n   = end_pend;
    padd_n   = pad_done;
    buf_clr  = 1'b0;
    buf_wr   = 1'b0;
    buf_len  = 1'b0;
    buf_byte = in_data;
    unique case (state)
      ST_FILL: begin
        if (in_valid) begin
          buf_wr = 1'b1;
          ptr_n  = ptr + 7'd1;
          cnt_n  = cnt + LEN_W'(1);
          if (ptr_n == 7'd64) begin
            state_n = ST_EMIT;
            last_n  = 1'b0;
            endp_n  = end_evt;
          end else if (end_evt) begin
            state_n = ST_PAD;
          end
        end else if (end_evt) begin
          state_n = ST_PAD;
        end
      end
      ST_PAD: begin
        buf_wr   = 1'b1;
        buf_byte = PAD_BYTE;
        ptr_n    = ptr + 7'd1;
        if (ptr_n <= 7'(LEN_POS)) begin
          state_n = ST_LEN;
        end else begin
          state_n = ST_EMIT;
          last_n  = 1'b0;
          padd_n  = 1'b1;
        end
      end
      ST_LEN: begin
        buf_len = 1'b1;
        state_n = ST_EMIT;
        last_n  = 1'b1;
      end
      ST_EMIT: begin
        if (blk_ready) begin
          buf_clr = 1'b1;
          ptr_n   = '0;
          first_n = 1'b0;
          // A data-full block may still owe a padding block (end_pend) or a length block (pad_done).
          if (last_q) begin
            state_n = ST_FILL;
            cnt_n   = '0;
            first_n = 1'b1;
            last_n  = 1'b0;
          end else if (end_pend) begin
            state_n = ST_PAD;
            endp_n  = 1'b0;
          end else if (pad_done) begin
            state_n = ST_LEN;
            padd_n  = 1'b0;
          end else begin
            state_n = ST_FILL;
          end
        end
      end
      default: state_n = ST_FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge KEY) begin
    if (!KEY) begin
      state      <= ST_FILL;
      ptr        <= '0;
      cnt        <= '0;
      first_pend <= 1'b1;
      last_q     <= 1'b0;
      end_pend   <= 1'b0;
      pad_done   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state      <= state_n;
      ptr        <= ptr_n;
      cnt        <= cnt_n;
      first_pend <= first_n;
      last_q     <= last_n;
      end_pend   <= endp_n;
      pad_done   <= padd_n;
      if (state != ST_FILL && (in_valid || in_end)) ovf_q <= 1'b1;
    end
  end

  sha256_pad_buf u_buf (
    .clk     (CLK),
    .rst_n   (KEY),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_idx  (ptr[5:0]),
    .wr_byte (buf_byte),
    .len_en  (buf_len),
    .len_val (len_val),
    .flat    (blk_data)
  );

  assign in_ready  = (state == ST_FILL);
  assign blk_valid = (state == ST_EMIT);
  assign blk_first = (state == ST_EMIT) && first_pend;
  assign blk_last  = (state == ST_EMIT) && last_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_sha256_msg_pad.sv
// Directed bench for sha256_msg_pad: known padded blocks, flags, backpressure, overflow, reset.
module tb_sha256_msg_pad;

  logic         CLK = 1'b0;
  logic         KEY = 1'b0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_end = 1'b0;
  logic         in_ready;
  logic [511:0] blk_data;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic         blk_first;
  logic         blk_last;
  logic         ovf;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  logic [511:0] exp_blk;

  sha256_msg_pad #(.LEN_W(32), .TIMEOUT_CYC(80000)) dut (
    .CLK       (CLK),
    .KEY       (KEY),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_end    (in_end),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_first (blk_first),
    .blk_last  (blk_last),
    .ovf       (ovf)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    @(negedge CLK);
    in_data  = b;
    in_valid = 1'b1;
    in_end   = e;
    @(negedge CLK);
    in_valid = 1'b0;
    in_end   = 1'b0;
  endtask

  task automatic send_end();
    @(negedge CLK);
    in_end = 1'b1;
    @(negedge CLK);
    in_end = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (blk_valid === 1'b1) break;
      @(negedge CLK);
    end
    check({tag, "_valid"}, {511'b0, blk_valid}, 512'd1);
  endtask

  task automatic take_blk(input string tag, input logic [511:0] exp, input logic f, input logic l);
    wait_valid(tag);
    check({tag, "_data"},  blk_data, exp);
    check({tag, "_first"}, {511'b0, blk_first}, {511'b0, f});
    check({tag, "_last"},  {511'b0, blk_last},  {511'b0, l});
    blk_ready = 1'b1;
    @(negedge CLK);
    blk_ready = 1'b0;
  endtask

  task automatic send_abc();
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b1);
  endtask

  initial begin
    // reset state
    #12;
    check("rst_valid", {511'b0, blk_valid}, 512'd0);
    check("rst_data",  blk_data, 512'd0);
    check("rst_flags", {509'b0, blk_first, blk_last, ovf}, 512'd0);
    @(negedge CLK);
    KEY = 1'b1;
    @(negedge CLK);
    check("rst_in_ready", {511'b0, in_ready}, 512'd1);

    // 1: "abc"
    exp_blk = '0;
    exp_blk[511:480] = 32'h61626380;
    exp_blk[63:0]    = 64'h18;
    send_abc();
    take_blk("t1", exp_blk, 1'b1, 1'b1);
    @(negedge CLK);
    check("t1_idle", {510'b0, blk_valid, in_ready}, 512'd1);

    // 2: empty message
    exp_blk = '0;
    exp_blk[511:504] = 8'h80;
    send_end();
    take_blk("t2", exp_blk, 1'b1, 1'b1);

    // 3: 56 zero bytes, standalone end -> pad in first block, length in second
    for (int i = 0; i < 56; i++) send_byte(8'h00, 1'b0);
    send_end();
    exp_blk = '0;
    exp_blk[63:56] = 8'h80;
    take_blk("t3a", exp_blk, 1'b1, 1'b0);
    exp_blk = '0;
    exp_blk[63:0] = 64'h1C0;
    take_blk("t3b", exp_blk, 1'b0, 1'b1);

    // 4: 64 bytes (value = index + 1), end with the last byte
    exp_blk = '0;
    for (int i = 0; i < 64; i++) begin
      send_byte(8'(i + 1), (i == 63));
      exp_blk[511 - 8*i -: 8] = 8'(i + 1);
    end
    take_blk("t4a", exp_blk, 1'b1, 1'b0);
    exp_blk = '0;
    exp_blk[511:504] = 8'h80;
    exp_blk[63:0]    = 64'h200;
    take_blk("t4b", exp_blk, 1'b0, 1'b1);
    exp_blk = '0;
    exp_blk[511:480] = 32'h61626380;
    exp_blk[63:0]    = 64'h18;
    send_abc();
    take_blk("t4c", exp_blk, 1'b1, 1'b1);

    // 5: backpressure with a byte pushed during EMIT
    check("t5_ovf_pre", {511'b0, ovf}, 512'd0);
    send_abc();
    wait_valid("t5");
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        check("t5_in_ready", {511'b0, in_ready}, 512'd0);
        in_data  = 8'h55;
        in_valid = 1'b1;
      end
      @(negedge CLK);
      in_valid = 1'b0;
    end
    check("t5_ovf",  {511'b0, ovf}, 512'd1);
    check("t5_hold", {511'b0, blk_valid}, 512'd1);
    check("t5_data", blk_data, exp_blk);
    blk_ready = 1'b1;
    @(negedge CLK);
    blk_ready = 1'b0;
    check("t5_once", {510'b0, blk_valid, in_ready}, 512'd1);

    // 6: reset mid-message, then "abc" again
    for (int i = 0; i < 10; i++) send_byte(8'hA5, 1'b0);
    @(negedge CLK);
    KEY = 1'b0;
    #2;
    check("t6_rst_ovf",  {511'b0, ovf}, 512'd0);
    check("t6_rst_data", blk_data, 512'd0);
    @(negedge CLK);
    KEY = 1'b1;
    send_abc();
    take_blk("t6", exp_blk, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
